branch_hazard_ctrl: RTL

- Decode-stage controller that schedules branch resolution for the branch comparator.
- Keeps its own shadow of in-flight destination registers in E/M/W.
- From that shadow it decides whether a decode-stage branch must stall, and which source feeds each comparator operand (regfile, M ALU result, W result).
- Also keeps wrap-around performance counters for resolved branches, taken branches and branch stall cycles.

---
 rtl/branch_hazard_if.sv | 35 +++
 rtl/branch_hazard_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/branch_hazard_if.sv
// Decode-stage branch hazard bus: the pipeline (master) presents decode and
// control info, the hazard controller (slave) returns stall/forward/issue/counters.
interface branch_hazard_if #(parameter int CNT_W = 32);
  logic             branchD;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic             uses_rtD;
  logic             regwriteD;
  logic [4:0]       writeregD;
  logic             memtoregD;
  logic             pcsrcD;
  logic             stall_ext;
  logic             flush_ext;
  logic             stallD;
  logic [1:0]       forwardaD;
  logic [1:0]       forwardbD;
  logic             branch_issue;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_stall;

  modport master (
    output branchD, rsD, rtD, uses_rtD, regwriteD, writeregD, memtoregD,
           pcsrcD, stall_ext, flush_ext,
    input  stallD, forwardaD, forwardbD, branch_issue,
           cnt_branch, cnt_taken, cnt_stall
  );

  modport slave (
    input  branchD, rsD, rtD, uses_rtD, regwriteD, writeregD, memtoregD,
           pcsrcD, stall_ext, flush_ext,
    output stallD, forwardaD, forwardbD, branch_issue,
           cnt_branch, cnt_taken, cnt_stall
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch operand hazard controller: shadows E/M/W destinations to stall or
// forward decode-stage branch comparisons, and counts branch events.
module branch_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  branch_hazard_if.slave bus
);
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } sh_t;

  sh_t              e_q, e_d, m_q, m_d;
  logic             w_vld_q, w_vld_d;
  logic [4:0]       w_rd_q, w_rd_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic [2:0] ha, hb;
  logic       stall, issue, stall_cnt;
  logic [1:0] fa, fb;

  // Returns {stall, fwd[1:0]} for one operand; M is checked before W.
  function automatic logic [2:0] chk(input logic [4:0] r, input logic en,
                                     input sh_t e, input sh_t m,
                                     input logic wv, input logic [4:0] wr);
    chk = 3'b000;
    if (en && r != 5'd0) begin
      if ((e.vld && e.rd == r) || (m.vld && m.ld && m.rd == r)) chk = 3'b100;
      else if (m.vld && m.rd == r)                                chk = 3'b001;
      else if (wv && wr == r)                                     chk = 3'b010;
    end
  endfunction

  always_comb begin
    ha        = chk(bus.rsD, 1'b1, e_q, m_q, w_vld_q, w_rd_q);
    hb        = chk(bus.rtD, bus.uses_rtD, e_q, m_q, w_vld_q, w_rd_q);
    stall     = resetn & bus.branchD & (ha[2] | hb[2]);
    fa        = (resetn & bus.branchD & !stall) ? ha[1:0] : 2'b00;
    fb        = (resetn & bus.branchD & !stall) ? hb[1:0] : 2'b00;
    issue     = resetn & bus.branchD & !stall & !bus.stall_ext & !bus.flush_ext;
    stall_cnt = stall & !bus.stall_ext & !bus.flush_ext;
  end

  always_comb begin
    e_d     = e_q;
    m_d     = m_q;
    w_vld_d = w_vld_q;
    w_rd_d  = w_rd_q;
    if (bus.flush_ext) begin
      e_d.vld = 1'b0;
      m_d.vld = 1'b0;
      w_vld_d = 1'b0;
    end else if (!bus.stall_ext) begin
      m_d     = e_q;
      w_vld_d = m_q.vld;
      w_rd_d  = m_q.rd;
      // A stalled branch stays in D, so a bubble goes down the pipe instead.
      e_d = stall ? sh_t'('0)
                  : '{vld: bus.regwriteD && (bus.writeregD != 5'd0),
                      rd: bus.writeregD, ld: bus.memtoregD};
    end
    cnt_branch_d = cnt_branch_q + {{(CNT_W-1){1'b0}}, issue};
    cnt_taken_d  = cnt_taken_q  + {{(CNT_W-1){1'b0}}, issue & bus.pcsrcD};
    cnt_stall_d  = cnt_stall_q  + {{(CNT_W-1){1'b0}}, stall_cnt};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_q          <= '0;
      m_q          <= '0;
      w_vld_q      <= 1'b0;
      w_rd_q       <= 5'd0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      e_q          <= e_d;
      m_q          <= m_d;
      w_vld_q      <= w_vld_d;
      w_rd_q       <= w_rd_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign bus.stallD       = stall;
  assign bus.forwardaD    = fa;
  assign bus.forwardbD    = fb;
  assign bus.branch_issue = issue;
  assign bus.cnt_branch   = cnt_branch_q;
  assign bus.cnt_taken    = cnt_taken_q;
  assign bus.cnt_stall    = cnt_stall_q;
endmodule
